db_arbiter: RTL

DB_ARBITER -- requirements
Module: db_arbiter

---
 rtl/db_arb_pkg.sv | 38 +++
 rtl/sync2.sv | 22 ++
 rtl/db_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/db_arb_pkg.sv
// Shared types and constants for the four-channel debounce arbiter.
package db_arb_pkg;

    // Number of switch channels; the arbitration logic is written for four.
    localparam int unsigned CH_NUM = 4;

    // Default countdown width: a 2^21-1 cycle settle window, about 40 ms at 50 MHz.
    localparam int unsigned N_DEFAULT = 21;

    // IDLE: timer free, looking for a pending channel. WAIT: timer owned by one channel.
    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    // Result of a round-robin search over the pending vector.
    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // First pending channel at offset 0..3 from ptr. Scanning from the far end
    // lets the closest hit overwrite the result last.
    function automatic pick_t rr_pick(input logic [CH_NUM-1:0] pend, input logic [1:0] ptr);
        pick_t      res;
        logic [1:0] idx;
        res = '{found: 1'b0, idx: 2'd0};
        for (int k = CH_NUM - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (pend[idx]) begin
                res.found = 1'b1;
                res.idx   = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous input bit.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; the first stage may go metastable, the second resolves it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/db_arbiter.sv
// Four switch debouncers sharing one settle timer, granted round-robin.
// A channel whose synchronized input differs from its debounced level asks for
// the timer; it commits the new level only if the input holds for the full window.
module db_arbiter
    import db_arb_pkg::*;
#(
    parameter int unsigned N  = N_DEFAULT,
    parameter int unsigned CH = CH_NUM
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH-1:0] sw,
    output logic [CH-1:0] db_level,
    output logic [CH-1:0] db_tick,
    output logic          busy,
    output logic [1:0]    grant_id
);

    localparam logic [N-1:0] QOne = {{(N-1){1'b0}}, 1'b1};

    logic [CH-1:0] ss;
    logic [CH-1:0] pending;

    state_t        state_q, state_d;
    logic [N-1:0]  q_q, q_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    gid_q, gid_d;
    logic [CH-1:0] level_q, level_d;
    logic [CH-1:0] tick_q, tick_d;
    pick_t         pick;

    for (genvar i = 0; i < CH; i++) begin : g_sync
        sync2 u_sync2 (
            .clk   (clk),
            .reset (reset),
            .d     (sw[i]),
            .q     (ss[i])
        );
    end

    assign pending = ss ^ level_q;

    // Arbitration, countdown and commit/abort decisions.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        level_d = level_q;
        tick_d  = '0;
        pick    = rr_pick(pending, ptr_q);
        unique case (state_q)
            IDLE: begin
                if (pick.found) begin
                    q_d     = '1;
                    gid_d   = pick.idx;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!pending[gid_q]) begin
                    // Input bounced back to the committed level: release the timer.
                    state_d = IDLE;
                    ptr_d   = gid_q + 2'd1;
                end else if (q_q == QOne) begin
                    level_d[gid_q] = ~level_q[gid_q];
                    tick_d[gid_q]  = ~level_q[gid_q];  // pulse on rising commits only
                    state_d        = IDLE;
                    ptr_d          = gid_q + 2'd1;
                end else begin
                    q_d = q_q - QOne;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset clears everything including mid-window progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            ptr_q   <= 2'd0;
            gid_q   <= 2'd0;
            level_q <= '0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            level_q <= level_d;
            tick_q  <= tick_d;
        end
    end

    assign busy     = (state_q == WAIT);
    assign grant_id = busy ? gid_q : 2'd0;
    assign db_level = level_q;
    assign db_tick  = tick_q;

endmodule
